// File: rtl/fifo_reader.sv
// Read-side controller for a registered-output FIFO: issues pops, absorbs the
// one-cycle RAM read latency in a 3-entry skid queue, presents a valid/ready stream.
module fifo_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  pop_count
);

   logic [DATA_WIDTH-1:0] queue [0:2];
   logic [1:0]            head;
   logic [1:0]            tail;
   logic [1:0]            cnt;
   logic                  inflight;
   logic [2:0]            occupancy;
   logic                  capture;
   logic                  deliver;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Issue only reads registered state, so out_ready never reaches fifo_rd_en.
   always_comb begin
      occupancy  = {1'b0, cnt} + {2'b00, inflight};
      fifo_rd_en = !rst && !flush && !fifo_empty && (occupancy < 3'd3);
      out_valid  = (cnt != 2'd0);
      out_data   = queue[head];
      capture    = inflight && !flush;
      deliver    = out_valid && out_ready && !flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head      <= 2'd0;
         tail      <= 2'd0;
         cnt       <= 2'd0;
         inflight  <= 1'b0;
         pop_count <= '0;
      end else if (flush) begin
         head     <= 2'd0;
         tail     <= 2'd0;
         cnt      <= 2'd0;
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         if (capture) begin
            tail <= next_ptr(tail);
         end
         if (deliver) begin
            head      <= next_ptr(head);
            pop_count <= pop_count + 1'b1;
         end
         case ({capture, deliver})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; contents are only observed while cnt says they are live.
   always_ff @(posedge clk) begin
      if (!rst && capture) begin
         queue[tail] <= fifo_dout;
      end
   end

endmodule
